// File: rtl/energy_pkg.sv
// Shared types and defaults for the prepaid energy-credit consumer.
package energy_pkg;

    localparam int ENERGY_W       = 8;
    localparam int CREDIT_W_DEF   = 10;
    localparam int LOW_THRESH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        LOW       = 2'd2,
        EXHAUSTED = 2'd3
    } state_t;

endpackage

// File: rtl/sat_addsub.sv
// Combinational saturating add (ceiling at max_val) followed by a floor-at-zero subtract.
module sat_addsub #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] max_val,
    input  logic [W-1:0] sub,
    output logic [W-1:0] result
);

    logic [W:0]   wide_sum;
    logic [W-1:0] sum;

    always_comb begin
        wide_sum = {1'b0, a} + {1'b0, b};
        sum      = (wide_sum > {1'b0, max_val}) ? max_val : wide_sum[W-1:0];
        result   = (sum > sub) ? (sum - sub) : '0;
    end

endmodule

// File: rtl/energy_credit_drain.sv
// Deducts per-cycle energy consumption from a prepaid credit register and drives room power.
module energy_credit_drain
    import energy_pkg::*;
#(
    parameter int CREDIT_W   = CREDIT_W_DEF,
    parameter int LOW_THRESH = LOW_THRESH_DEF,
    parameter int MAX_CREDIT = 2**CREDIT_W - 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [ENERGY_W-1:0] energy,
    input  logic                topup_valid,
    input  logic [CREDIT_W-1:0] topup_amount,
    output logic                topup_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                power_on,
    output logic                low_warn,
    output logic [1:0]          state
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] LOW_C = CREDIT_W'(LOW_THRESH);

    state_t              state_q;
    state_t              state_next;
    logic [ENERGY_W-1:0] last_energy;
    logic                primed;
    logic [ENERGY_W-1:0] delta;
    logic [CREDIT_W-1:0] add;
    logic [CREDIT_W-1:0] credit_next;
    logic                power_on_next;
    logic                low_warn_next;

    assign topup_ready = (credit != MAX_C);
    assign state       = state_q;

    // Modulo-256 difference absorbs the counter wrap; suppressed until a prior sample exists.
    always_comb begin
        delta = '0;
        if (primed && enable) begin
            delta = energy - last_energy;
        end
        add = (topup_valid && topup_ready) ? topup_amount : '0;
    end

    sat_addsub #(
        .W(CREDIT_W)
    ) u_sat_addsub (
        .a      (credit),
        .b      (add),
        .max_val(MAX_C),
        .sub    (CREDIT_W'(delta)),
        .result (credit_next)
    );

    always_comb begin
        state_next    = state_q;
        power_on_next = 1'b0;
        low_warn_next = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else if (credit_next == '0) begin
            state_next = EXHAUSTED;
        end else if (credit_next <= LOW_C) begin
            state_next = LOW;
        end else begin
            state_next = ACTIVE;
        end
        power_on_next = (state_next == ACTIVE) || (state_next == LOW);
        low_warn_next = (state_next == LOW) && (state_q != LOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            power_on <= 1'b0;
            low_warn <= 1'b0;
        end else begin
            state_q  <= state_next;
            power_on <= power_on_next;
            low_warn <= low_warn_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit      <= '0;
            last_energy <= '0;
            primed      <= 1'b0;
        end else begin
            credit      <= credit_next;
            last_energy <= energy;
            primed      <= enable;
        end
    end

endmodule

// File: doc/energy_credit_drain.md
Name: energy_credit_drain

Overview:
- Prepaid energy-credit consumer; sits downstream of the room energy counter and reads its 8-bit wrapping energy count.
- Each cycle it subtracts the newly consumed energy units (the delta since the previous sample) from a credit register.
- Credit is refilled through a valid/ready top-up handshake.
- A 4-state FSM drives room power enable and a low-credit warning pulse.

Parameters:
- CREDIT_W, 10, credit register width.
- LOW_THRESH, 16, credit at or below this value is "low".
- MAX_CREDIT, 2**CREDIT_W-1, saturation ceiling for credit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  metering enabled; low means IDLE, no deduction.
- energy  in  8  current energy count from the energy counter; wraps 255->0.
- topup_valid  in  1  top-up request.
- topup_amount  in  CREDIT_W  credit to add.
- topup_ready  out  1  top-up is accepted when valid&&ready at a clk edge.
- credit  out  CREDIT_W  registered remaining credit.
- power_on  out  1  room power enable.
- low_warn  out  1  one-cycle pulse when the FSM enters LOW.
- state  out  2  FSM state code, for debug.

Behaviour:
- Reset values: credit=0, last_energy=0, primed=0, state=IDLE, power_on=0, low_warn=0, topup_ready=1. Reset applies asynchronously at any time, including mid-top-up; a top-up in flight is discarded.
- Delta: delta = (energy - last_energy) mod 256, 8-bit unsigned, so wrap is handled (e.g. last=250, energy=3 gives delta=9).
  - Forced to 0 when primed=0 or enable=0.
- last_energy <= energy every cycle, regardless of enable.
- primed <= enable. The first enabled cycle after reset or after enable rises therefore deducts 0.
- Credit update, registered with 1-cycle latency:
  - add = topup_valid&&topup_ready ? topup_amount : 0.
  - sum = min(credit + add, MAX_CREDIT).
  - credit_next = (sum > delta) ? sum - delta : 0.
  - A simultaneous top-up and deduction applies the add first, then the subtract. Both steps saturate.
- topup_ready = (credit != MAX_CREDIT), combinational from credit. A top-up at MAX is not accepted. A partial top-up that overflows is accepted and clipped to MAX.
- FSM states are IDLE=0, ACTIVE=1, LOW=2, EXHAUSTED=3. Transitions are evaluated on credit_next:
  - Any state with enable=0 -> IDLE.
  - Otherwise:
    - credit_next==0 -> EXHAUSTED.
    - 0<credit_next<=LOW_THRESH -> LOW.
    - credit_next>LOW_THRESH -> ACTIVE.
  - This applies from every state, including leaving EXHAUSTED after a top-up.
- Outputs, all registered:
  - power_on = 1 in ACTIVE and LOW, 0 in IDLE and EXHAUSTED.
  - low_warn = 1 for one cycle on the edge where the next state is LOW and the current state is not LOW. Going directly from ACTIVE to EXHAUSTED produces no warn.
- Boundary conditions:
  - delta greater than credit clamps credit to 0.
  - delta=0 means credit holds.
  - A top-up of amount 0 is accepted and has no effect.
  - Credit never wraps in either direction.

Decomposition:
- Package energy_pkg holds the state enum (IDLE, ACTIVE, LOW, EXHAUSTED, 2-bit), ENERGY_W=8, and the default widths and thresholds.
- One sub-module, sat_addsub #(W): combinational, computes min(a+b,MAX) then a floor-at-0 subtract. It is reusable by the energy counter side.

Test Plan:
- Reset then enable=1, energy=37 held -> first cycle delta forced 0; credit=0, state=EXHAUSTED, power_on=0.
- Top-up 100 with valid=1 for 1 cycle -> credit=100 next cycle, state=ACTIVE, power_on=1, topup_ready stays 1.
- Credit 20, energy steps 37->41 -> credit=16, state LOW, low_warn pulse exactly 1 cycle; a further step 41->43 -> credit=14 with no second pulse.
- Credit 14, last_energy=250, energy=3 (wrap, delta=9) -> credit=5. Next, energy 3->20 (delta=17) -> credit=0, EXHAUSTED, power_on=0.
- Credit 1000, top-up 50 with simultaneous delta 10 -> sum clipped to 1023, then 1013. At credit=1023, topup_ready=0 and a valid request leaves credit unchanged.
- In ACTIVE with credit 500, assert reset asynchronously mid-cycle -> outputs go to reset values immediately without waiting for clk. Dropping enable -> IDLE, power_on=0, credit held while energy changes.
